zap_wb_arb2: RTL and testbench
==============================

ZAP_WB_ARB2 -- requirements
Module: zap_wb_arb2

Interface
Parameters: none.
REQ-001 i_clk  input  1  core clock; all flops rising-edge.
REQ-002 i_reset  input  1  synchronous, active-high reset.
REQ-003 i_p0_wb_cyc_nxt  input  1  port 0 (TLB page-walk FSM) next-cycle CYC.
REQ-004 i_p0_wb_stb_nxt  input  1  port 0 next-cycle STB.
REQ-005 i_p0_wb_adr_nxt  input  32  port 0 next-cycle address.
REQ-006 i_p0_wb_sel_nxt  input  4  port 0 next-cycle byte select; port 0 is read-only.
REQ-007 i_p1_wb_cyc_nxt  input  1  port 1 (cache line FSM) next-cycle CYC.
REQ-008 i_p1_wb_stb_nxt  input  1  port 1 next-cycle STB.
REQ-009 i_p1_wb_adr_nxt  input  32  port 1 next-cycle address.
REQ-010 i_p1_wb_sel_nxt  input  4  port 1 next-cycle byte select.
REQ-011 i_p1_wb_we_nxt  input  1  port 1 next-cycle write enable.
REQ-012 i_p1_wb_dat_nxt  input  32  port 1 next-cycle write data.
REQ-013 o_wb_cyc  output  1  registered bus CYC.
REQ-014 o_wb_stb  output  1  registered bus STB.
REQ-015 o_wb_adr  output  32  registered bus address.
REQ-016 o_wb_sel  output  4  registered bus byte select.
REQ-017 o_wb_we  output  1  registered bus write enable.
REQ-018 o_wb_dat  output  32  registered bus write data.
REQ-019 i_wb_ack  input  1  slave ACK; read data (i_wb_dat) goes to both requesters directly and does not pass through this block.
REQ-020 o_p0_wb_ack  output  1  ACK routed to port 0.
REQ-021 o_p1_wb_ack  output  1  ACK routed to port 1.

Function
REQ-022 States SHALL be IDLE, GRANT0 and GRANT1, held in a 2-bit state register, plus a 1-bit last-owner flop last_ff.
REQ-023 In IDLE:
- only p0 cyc_nxt=1 -> GRANT0;
- only p1 cyc_nxt=1 -> GRANT1;
- both=1 -> grant port !last_ff (round-robin);
- neither -> stay in IDLE.
REQ-024 On each grant, last_ff SHALL load the granted port number.
REQ-025 On the edge entering GRANTx, bus registers SHALL load port x's nxt signals, so o_wb_cyc rises one cycle after the requester's cyc_nxt.
REQ-026 In GRANTx while port x cyc_nxt=1, bus registers SHALL load port x's nxt signals every cycle.
REQ-027 Port 0 we/dat SHALL be forced to 0.
REQ-028 In GRANTx when port x cyc_nxt=0, the next state SHALL be IDLE and bus registers SHALL load all-zero.
REQ-029 Between owners there SHALL always be at least one cycle with o_wb_cyc=0; direct GRANT0<->GRANT1 transitions are prohibited.
REQ-030 In IDLE, bus registers SHALL load all-zero unless a grant is made that cycle.
REQ-031 o_p0_wb_ack SHALL equal i_wb_ack & (state==GRANT0), and o_p1_wb_ack SHALL equal i_wb_ack & (state==GRANT1); both are combinational with zero latency.
REQ-032 i_wb_ack arriving in IDLE SHALL be discarded: no ACK to either port.
REQ-033 The non-granted port's nxt inputs SHALL be ignored, and no ACK is returned to it. It holds its request until granted; no grant signal is exported.
REQ-034 A request rising in the same cycle the other port releases SHALL be serviced from IDLE on the following cycle.
REQ-035 Sustained requests from both ports SHALL alternate ownership, so neither port waits more than one full transaction of the other.
REQ-036 Ports use the nxt protocol: the requester keeps cyc_nxt=1 until its ACK and drops it after the ACK.

Reset
REQ-037 While i_reset=1 at a clock edge:
- state <= IDLE, last_ff <= 1;
- o_wb_cyc, o_wb_stb, o_wb_we <= 0;
- o_wb_adr, o_wb_dat <= 0, o_wb_sel <= 0.
REQ-038 Reset mid-transaction SHALL abort the transaction: outputs are zero one cycle after the edge, and acks are suppressed from that edge on.
REQ-039 After reset release, a simultaneous first request SHALL be granted to port 0.

Verification
REQ-040 Reset, then p0 cyc/stb_nxt=1, adr_nxt=0x0000_4008, sel=F -> next cycle o_wb_cyc=1, adr=0x0000_4008, we=0; ack on cycle 3 -> o_p0_wb_ack=1, o_p1_wb_ack=0.
REQ-041 Both ports request in the same cycle after reset -> port 0 granted; after p0 drops cyc_nxt there is one idle cycle, then port 1 is granted with adr=0x8000_0000, we=1, dat=0xDEAD_BEEF.
REQ-042 Both ports request continuously for 4 transactions -> owner sequence 0,1,0,1, with o_wb_cyc=0 for exactly one cycle between each.
REQ-043 i_wb_ack pulsed while IDLE -> both port acks remain 0 and the state is unchanged.
REQ-044 i_reset asserted during a GRANT1 write -> next cycle all outputs are 0 and the state is IDLE; a following simultaneous request is granted to port 0.
REQ-045 p1 drops cyc_nxt in the same cycle that p0 raises it -> one cycle of o_wb_cyc=0, then GRANT0 with p0's address.

Source files
------------

// File: rtl/zap_wb_arb2.sv
// Two-port Wishbone arbiter: page-walk FSM (port 0) and cache line FSM
// (port 1) share one registered bus with round-robin ownership.
module zap_wb_arb2 (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_p0_wb_cyc_nxt,
  input  logic        i_p0_wb_stb_nxt,
  input  logic [31:0] i_p0_wb_adr_nxt,
  input  logic [3:0]  i_p0_wb_sel_nxt,
  input  logic        i_p1_wb_cyc_nxt,
  input  logic        i_p1_wb_stb_nxt,
  input  logic [31:0] i_p1_wb_adr_nxt,
  input  logic [3:0]  i_p1_wb_sel_nxt,
  input  logic        i_p1_wb_we_nxt,
  input  logic [31:0] i_p1_wb_dat_nxt,
  output logic        o_wb_cyc,
  output logic        o_wb_stb,
  output logic [31:0] o_wb_adr,
  output logic [3:0]  o_wb_sel,
  output logic        o_wb_we,
  output logic [31:0] o_wb_dat,
  input  logic        i_wb_ack,
  output logic        o_p0_wb_ack,
  output logic        o_p1_wb_ack
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } state_t;

  state_t      state_ff;
  state_t      state_nxt;
  logic        last_ff;
  logic        last_nxt;
  logic        load0;
  logic        load1;

  logic        cyc_nxt;
  logic        stb_nxt;
  logic [31:0] adr_nxt;
  logic [3:0]  sel_nxt;
  logic        we_nxt;
  logic [31:0] dat_nxt;

  // Ownership is only ever handed out from IDLE, which forces the
  // one-cycle CYC gap between owners.
  always_comb begin
    state_nxt = state_ff;
    last_nxt  = last_ff;
    load0     = 1'b0;
    load1     = 1'b0;
    unique case (state_ff)
      IDLE: begin
        if (i_p0_wb_cyc_nxt &&
            (!i_p1_wb_cyc_nxt || last_ff)) begin
          state_nxt = GRANT0;
          last_nxt  = 1'b0;
          load0     = 1'b1;
        end else if (i_p1_wb_cyc_nxt) begin
          state_nxt = GRANT1;
          last_nxt  = 1'b1;
          load1     = 1'b1;
        end
      end
      GRANT0: begin
        if (i_p0_wb_cyc_nxt) load0 = 1'b1;
        else state_nxt = IDLE;
      end
      GRANT1: begin
        if (i_p1_wb_cyc_nxt) load1 = 1'b1;
        else state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cyc_nxt = 1'b0;
    stb_nxt = 1'b0;
    adr_nxt = 32'd0;
    sel_nxt = 4'd0;
    we_nxt  = 1'b0;
    dat_nxt = 32'd0;
    if (load0) begin
      cyc_nxt = i_p0_wb_cyc_nxt;
      stb_nxt = i_p0_wb_stb_nxt;
      adr_nxt = i_p0_wb_adr_nxt;
      sel_nxt = i_p0_wb_sel_nxt;
    end else if (load1) begin
      cyc_nxt = i_p1_wb_cyc_nxt;
      stb_nxt = i_p1_wb_stb_nxt;
      adr_nxt = i_p1_wb_adr_nxt;
      sel_nxt = i_p1_wb_sel_nxt;
      we_nxt  = i_p1_wb_we_nxt;
      dat_nxt = i_p1_wb_dat_nxt;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_ff <= IDLE;
      last_ff  <= 1'b1;
      o_wb_cyc <= 1'b0;
      o_wb_stb <= 1'b0;
      o_wb_adr <= 32'd0;
      o_wb_sel <= 4'd0;
      o_wb_we  <= 1'b0;
      o_wb_dat <= 32'd0;
    end else begin
      state_ff <= state_nxt;
      last_ff  <= last_nxt;
      o_wb_cyc <= cyc_nxt;
      o_wb_stb <= stb_nxt;
      o_wb_adr <= adr_nxt;
      o_wb_sel <= sel_nxt;
      o_wb_we  <= we_nxt;
      o_wb_dat <= dat_nxt;
    end
  end

  assign o_p0_wb_ack = i_wb_ack & (state_ff == GRANT0);
  assign o_p1_wb_ack = i_wb_ack & (state_ff == GRANT1);

endmodule

// File: tb/tb_zap_wb_arb2.sv
// Scoreboard bench for zap_wb_arb2: random requesters and slave,
// ownership-level reference model, directed round-robin sequence.
module tb_zap_wb_arb2;

  logic        clk;
  logic        rst;
  logic        p0_cyc, p0_stb;
  logic [31:0] p0_adr;
  logic [3:0]  p0_sel;
  logic        p1_cyc, p1_stb, p1_we;
  logic [31:0] p1_adr, p1_dat;
  logic [3:0]  p1_sel;
  logic        wb_cyc, wb_stb, wb_we;
  logic [31:0] wb_adr, wb_dat;
  logic [3:0]  wb_sel;
  logic        ack, ack0, ack1;

  zap_wb_arb2 dut (
    .i_clk           (clk),
    .i_reset         (rst),
    .i_p0_wb_cyc_nxt (p0_cyc),
    .i_p0_wb_stb_nxt (p0_stb),
    .i_p0_wb_adr_nxt (p0_adr),
    .i_p0_wb_sel_nxt (p0_sel),
    .i_p1_wb_cyc_nxt (p1_cyc),
    .i_p1_wb_stb_nxt (p1_stb),
    .i_p1_wb_adr_nxt (p1_adr),
    .i_p1_wb_sel_nxt (p1_sel),
    .i_p1_wb_we_nxt  (p1_we),
    .i_p1_wb_dat_nxt (p1_dat),
    .o_wb_cyc        (wb_cyc),
    .o_wb_stb        (wb_stb),
    .o_wb_adr        (wb_adr),
    .o_wb_sel        (wb_sel),
    .o_wb_we         (wb_we),
    .o_wb_dat        (wb_dat),
    .i_wb_ack        (ack),
    .o_p0_wb_ack     (ack0),
    .o_p1_wb_ack     (ack1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  logic [70:0] expq[$];
  int          owner = -1;
  int          last = 1;
  bit          dir_phase = 0;
  logic [31:0] seen[$];

  bit          reqv[2];
  int          gap[2];
  logic        a0, a1;

  task automatic chk(input string nm,
                     input logic [127:0] act,
                     input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h",
               nm, act, exp);
    end
  endtask

  function automatic logic [70:0] pword(input int p);
    if (p == 0)
      return {p0_cyc, p0_stb, p0_adr, p0_sel,
              1'b0, 32'd0};
    return {p1_cyc, p1_stb, p1_adr, p1_sel,
            p1_we, p1_dat};
  endfunction

  // Reference: an owner is chosen only when the bus is free, and
  // keeps the bus for as long as it holds its request.
  initial forever begin
    int pick;
    @(posedge clk);
    if (rst) begin
      owner = -1;
      last  = 1;
      expq.push_back('0);
    end else begin
      if (owner < 0) begin
        pick = -1;
        if (p0_cyc && p1_cyc) pick = 1 - last;
        else if (p0_cyc) pick = 0;
        else if (p1_cyc) pick = 1;
        if (pick >= 0) begin
          owner = pick;
          last  = pick;
        end
      end else if (!((owner == 0) ? p0_cyc : p1_cyc)) begin
        owner = -1;
      end
      expq.push_back((owner < 0) ? 71'd0 : pword(owner));
    end
  end

  initial begin
    logic [70:0] e;
    logic        prev_cyc;
    prev_cyc = 1'b0;
    @(posedge clk);
    forever begin
      @(negedge clk);
      if (expq.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL queue empty at %0t", $time);
      end else begin
        e = expq.pop_front();
        chk("bus",
            {wb_cyc, wb_stb, wb_adr, wb_sel, wb_we, wb_dat},
            e);
      end
      chk("ack0", ack0, ack && owner == 0);
      chk("ack1", ack1, ack && owner == 1);
      if (dir_phase && wb_cyc && !prev_cyc)
        seen.push_back(wb_adr);
      prev_cyc = wb_cyc;
    end
  end

  task automatic step();
    @(negedge clk);
    a0 = ack0;
    a1 = ack1;
    @(posedge clk);
    #1;
  endtask

  task automatic newdata(input int p, input bit dir);
    if (p == 0) begin
      p0_stb = dir ? 1'b1 : ($urandom_range(0, 7) != 0);
      p0_adr = dir ? 32'h0000_4008 : $urandom;
      p0_sel = dir ? 4'hF : 4'($urandom);
    end else begin
      p1_stb = dir ? 1'b1 : ($urandom_range(0, 7) != 0);
      p1_adr = dir ? 32'h8000_0000 : $urandom;
      p1_sel = dir ? 4'hF : 4'($urandom);
      p1_we  = dir ? 1'b1 : 1'($urandom);
      p1_dat = dir ? 32'hDEAD_BEEF : $urandom;
    end
  endtask

  task automatic update(input bit dir);
    bit acked;
    for (int p = 0; p < 2; p++) begin
      acked = (p == 0) ? a0 : a1;
      if (reqv[p] && acked) begin
        reqv[p] = 0;
        gap[p] = dir ? 0 : $urandom_range(0, 3);
      end else if (!reqv[p]) begin
        if (gap[p] > 0) gap[p]--;
        else if (dir || $urandom_range(0, 2) == 0) begin
          reqv[p] = 1;
          newdata(p, dir);
        end
      end
    end
    if (!reqv[0]) begin
      p0_adr = $urandom;
      p0_stb = 1'($urandom);
    end
    if (!reqv[1]) begin
      p1_adr = $urandom;
      p1_we  = 1'($urandom);
    end
    p0_cyc = reqv[0];
    p1_cyc = reqv[1];
    ack = dir ? 1'b1 : ($urandom_range(0, 2) == 0);
  endtask

  initial begin
    logic [31:0] dir_exp[4];
    dir_exp[0] = 32'h0000_4008;
    dir_exp[1] = 32'h8000_0000;
    dir_exp[2] = 32'h0000_4008;
    dir_exp[3] = 32'h8000_0000;
    rst = 1'b1;
    ack = 1'b0;
    p0_cyc = 0; p0_stb = 0; p0_adr = 0; p0_sel = 0;
    p1_cyc = 0; p1_stb = 0; p1_adr = 0; p1_sel = 0;
    p1_we = 0; p1_dat = 0;
    reqv[0] = 0; reqv[1] = 0;
    gap[0] = 0; gap[1] = 0;
    repeat (3) step();
    rst = 1'b0;
    dir_phase = 1;
    repeat (16) begin
      step();
      update(1);
    end
    dir_phase = 0;
    chk("dir_count", seen.size() >= 4, 1'b1);
    for (int i = 0; i < 4; i++)
      if (i < seen.size())
        chk($sformatf("dir_owner%0d", i), seen[i], dir_exp[i]);
    reqv[0] = 0; reqv[1] = 0;
    p0_cyc = 0; p1_cyc = 0;
    ack = 0;
    repeat (3) step();
    for (int c = 0; c < 3000; c++) begin
      step();
      if (rst) begin
        rst = 1'b0;
        update(0);
      end else if ($urandom_range(0, 149) == 0) begin
        rst = 1'b1;
        reqv[0] = 0; reqv[1] = 0;
        gap[0] = 0; gap[1] = 0;
        p0_cyc = 1'($urandom);
        p1_cyc = 1'($urandom);
        ack = 1'($urandom);
      end else begin
        update(0);
      end
    end
    rst = 1'b0;
    p0_cyc = 0; p1_cyc = 0; ack = 0;
    repeat (3) step();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
